// File: rtl/outport_arb_pkg.sv
// ---------------------------------------------------------------------------
// outport_arb_pkg
//   Shared definitions for the router output-port arbiter and its round-robin
//   picker: default port count and index width, port index names, the
//   arbiter state encoding and the default watchdog stall limit.
// ---------------------------------------------------------------------------
package outport_arb_pkg;

  localparam int ARB_NPORT   = 5;    // input ports competing for one output
  localparam int ARB_PTRW    = 3;    // width of a port index
  localparam int ARB_TIMEOUT = 255;  // default stall limit for the watchdog

  // Router port indices: 0 is the local core, 1-4 are the mesh directions.
  localparam int PORT_LOCAL = 0;
  localparam int PORT_NORTH = 1;
  localparam int PORT_EAST  = 2;
  localparam int PORT_SOUTH = 3;
  localparam int PORT_WEST  = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Next index after idx in a ring of n ports.
  function automatic int unsigned wrap_inc(int unsigned idx, int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/outport_arb_rr_pick.sv
// ---------------------------------------------------------------------------
// outport_arb_rr_pick
//   Combinational round-robin priority picker. Returns the first set bit of
//   cand, searching upward from ptr and wrapping NPORT-1 -> 0. Reusable by
//   any allocator that needs a rotating-priority choice.
//
//   Ports:
//     cand  in  NPORT  candidate request vector
//     ptr   in  PTRW   highest-priority index for this search
//     pick  out PTRW   chosen index (0 when any=0)
//     any   out 1      at least one candidate present
// ---------------------------------------------------------------------------
module outport_arb_rr_pick
  import outport_arb_pkg::*;
#(
  parameter int NPORT = ARB_NPORT,
  parameter int PTRW  = ARB_PTRW
) (
  input  logic [NPORT-1:0] cand,
  input  logic [PTRW-1:0]  ptr,
  output logic [PTRW-1:0]  pick,
  output logic             any
);

  always_comb begin
    int idx;
    // NOTE: every variable driven here gets a value before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    pick = '0;
    any  = 1'b0;
    idx  = 0;
    for (int i = 0; i < NPORT; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NPORT) idx = idx - NPORT;
      if (!any && cand[idx]) begin
        any  = 1'b1;
        pick = PTRW'(idx);
      end
    end
  end

endmodule

// File: rtl/outport_arb.sv
// ---------------------------------------------------------------------------
// outport_arb
//   Wormhole switch arbiter for one router output port. In IDLE it picks a
//   head-flit requester round-robin; the winner keeps the port from head to
//   tail, then becomes lowest priority. There is always one IDLE cycle
//   between packets.
//
//   Optional feature (macro OUTARB_WATCHDOG_EN): a stall counter forces a
//   release, as if a tail had crossed, after TIMEOUT cycles without a flit,
//   and pulses timeout for that cycle. Without the macro timeout is 0 and
//   the lock is held until the tail.
//
//   Ports:
//     clk      in   1      clock
//     rst_     in   1      synchronous reset, active-high
//     req      in   NPORT  input i has a valid flit routed here
//     hd       in   NPORT  input i's flit is a head flit
//     tl       in   NPORT  input i's flit is a tail flit (hd=tl: single flit)
//     ordy     in   1      output channel accepts a flit this cycle
//     grt      out  NPORT  registered one-hot grant, zero when unlocked
//     owner    out  PTRW   granted input, valid while locked
//     locked   out  1      port reserved by a packet
//     xfer     out  1      combinational: a flit crosses this cycle
//     timeout  out  1      one-cycle pulse on a watchdog release
// ---------------------------------------------------------------------------
module outport_arb
  import outport_arb_pkg::*;
#(
  parameter int NPORT   = ARB_NPORT,
  parameter int PTRW    = ARB_PTRW,
  parameter int TIMEOUT = ARB_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [NPORT-1:0] req,
  input  logic [NPORT-1:0] hd,
  input  logic [NPORT-1:0] tl,
  input  logic             ordy,
  output logic [NPORT-1:0] grt,
  output logic [PTRW-1:0]  owner,
  output logic             locked,
  output logic             xfer,
  output logic             timeout
);

  if (PTRW < $clog2(NPORT) || TIMEOUT < 1) begin : g_bad_param
    $error("outport_arb: PTRW too narrow for NPORT or TIMEOUT < 1");
  end

  arb_state_e       state_q, state_d;
  logic [NPORT-1:0] grt_q, grt_d;
  logic [PTRW-1:0]  owner_q, owner_d;
  logic [PTRW-1:0]  ptr_q, ptr_d;
  logic             timeout_q, timeout_d;

  logic [PTRW-1:0]  pick;
  logic             any;
  logic             tail_rel;
  logic             wd_hit;

  // Only head flits may open a packet; body flits waiting here are ignored.
  outport_arb_rr_pick #(
    .NPORT (NPORT),
    .PTRW  (PTRW)
  ) u_pick (
    .cand (req & hd),
    .ptr  (ptr_q),
    .pick (pick),
    .any  (any)
  );

  // grt_q is zero in IDLE, so xfer needs no explicit state term.
  assign xfer     = grt_q[owner_q] & req[owner_q] & ordy;
  assign tail_rel = xfer & tl[owner_q];

`ifdef OUTARB_WATCHDOG_EN
  localparam int CNTW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CNTW-1:0] stall_q;

  // Cleared in IDLE, so it always starts from zero on entry to LOCKED; it
  // saturates at TIMEOUT until the release takes effect.
  always_ff @(posedge clk) begin
    if (rst_) begin
      stall_q <= '0;
    end else if (state_q != LOCKED || xfer) begin
      stall_q <= '0;
    end else if (stall_q != CNTW'(TIMEOUT)) begin
      stall_q <= stall_q + CNTW'(1);
    end
  end

  assign wd_hit = (state_q == LOCKED) && (stall_q == CNTW'(TIMEOUT));
`else
  assign wd_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    grt_d     = grt_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any) begin
          state_d = LOCKED;
          grt_d   = NPORT'(1) << pick;
          owner_d = pick;
        end
      end
      LOCKED: begin
        if (tail_rel || wd_hit) begin
          state_d   = IDLE;
          grt_d     = '0;
          ptr_d     = PTRW'(wrap_inc(int'(owner_q), NPORT));
          // A tail crossing in the same cycle is a normal release.
          timeout_d = wd_hit & ~tail_rel;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its next value from the same pre-edge snapshot; reset is sampled on the
  // clock edge and wins over any in-flight packet.
  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q   <= IDLE;
      grt_q     <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grt_q     <= grt_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      timeout_q <= timeout_d;
    end
  end

  assign grt     = grt_q;
  assign owner   = owner_q;
  assign locked  = (state_q == LOCKED);
  assign timeout = timeout_q;

endmodule

// File: tb/tb_outport_arb.sv
// ---------------------------------------------------------------------------
// tb_outport_arb
//   Self-checking bench for outport_arb (NPORT=5, TIMEOUT=4). A table of
//   per-cycle vectors covers grant latency, a 3-flit packet, the round-robin
//   order and a head arriving mid-packet; hand-written sequences cover an
//   output stall, reset mid-packet and the hold/watchdog behaviour.
// ---------------------------------------------------------------------------
module tb_outport_arb;

  localparam int NPORT = 5;
  localparam int PTRW  = 3;

`ifdef OUTARB_WATCHDOG_EN
  localparam int ORDY_STALL = 3;   // stays below the stall limit
`else
  localparam int ORDY_STALL = 10;
`endif

  logic             clk;
  logic             rst_;
  logic [NPORT-1:0] req, hd, tl;
  logic             ordy;
  logic [NPORT-1:0] grt;
  logic [PTRW-1:0]  owner;
  logic             locked, xfer, timeout;

  int n_tests = 0;
  int n_fail  = 0;

  outport_arb #(
    .NPORT   (NPORT),
    .PTRW    (PTRW),
    .TIMEOUT (4)
  ) dut (
    .clk     (clk),
    .rst_    (rst_),
    .req     (req),
    .hd      (hd),
    .tl      (tl),
    .ordy    (ordy),
    .grt     (grt),
    .owner   (owner),
    .locked  (locked),
    .xfer    (xfer),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic [NPORT-1:0] req, hd, tl;
    logic             ordy;
    logic [NPORT-1:0] e_grt;
    int               e_owner;
    logic             e_locked;
    logic             e_xfer;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic [NPORT-1:0] r, h, t,
                         input logic o, input logic [NPORT-1:0] eg, input int eo,
                         input logic el, input logic ex);
    vec_t v;
    v.name = name; v.req = r; v.hd = h; v.tl = t; v.ordy = o;
    v.e_grt = eg; v.e_owner = eo; v.e_locked = el; v.e_xfer = ex;
    vecs.push_back(v);
  endtask

  // Drive one cycle's inputs, check outputs mid-cycle, then advance past
  // the next rising edge.
  task automatic cyc(input string name, input logic [NPORT-1:0] r, h, t,
                     input logic o, input logic [NPORT-1:0] eg, input int eo,
                     input logic el, input logic ex, input logic et);
    req = r; hd = h; tl = t; ordy = o;
    #1;
    check({name, ".grt"}, 32'(grt), 32'(eg));
    check({name, ".locked"}, 32'(locked), 32'(el));
    if (el) check({name, ".owner"}, 32'(owner), 32'(eo));
    check({name, ".xfer"}, 32'(xfer), 32'(ex));
    check({name, ".timeout"}, 32'(timeout), 32'(et));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: got expired, expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    // 3-flit packet on port 2, latency 1, release sets ptr=3.
    add_vec("p2_req",  5'b00100, 5'b00100, 5'b00000, 1, 5'b00000, 0, 0, 0);
    add_vec("p2_head", 5'b00100, 5'b00100, 5'b00000, 1, 5'b00100, 2, 1, 1);
    add_vec("p2_body", 5'b00100, 5'b00000, 5'b00000, 1, 5'b00100, 2, 1, 1);
    add_vec("p2_tail", 5'b00100, 5'b00000, 5'b00100, 1, 5'b00100, 2, 1, 1);
    // All ports send single-flit packets: order 3,4,0,1,2 from ptr=3.
    add_vec("rr_i3",   5'b11111, 5'b11111, 5'b11111, 0, 5'b00000, 0, 0, 0);
    add_vec("rr_g3",   5'b11111, 5'b11111, 5'b11111, 1, 5'b01000, 3, 1, 1);
    add_vec("rr_i4",   5'b11111, 5'b11111, 5'b11111, 1, 5'b00000, 0, 0, 0);
    add_vec("rr_g4",   5'b11111, 5'b11111, 5'b11111, 1, 5'b10000, 4, 1, 1);
    add_vec("rr_i0",   5'b11111, 5'b11111, 5'b11111, 1, 5'b00000, 0, 0, 0);
    add_vec("rr_g0",   5'b11111, 5'b11111, 5'b11111, 1, 5'b00001, 0, 1, 1);
    add_vec("rr_i1",   5'b11111, 5'b11111, 5'b11111, 1, 5'b00000, 0, 0, 0);
    add_vec("rr_g1",   5'b11111, 5'b11111, 5'b11111, 1, 5'b00010, 1, 1, 1);
    add_vec("rr_i2",   5'b11111, 5'b11111, 5'b11111, 1, 5'b00000, 0, 0, 0);
    add_vec("rr_g2",   5'b11111, 5'b11111, 5'b11111, 1, 5'b00100, 2, 1, 1);
    // Idle with non-head requests only: ignored, ptr stays 3.
    add_vec("idle_a",  5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 0, 0, 0);
    add_vec("nohead",  5'b11111, 5'b00000, 5'b00000, 1, 5'b00000, 0, 0, 0);
    // Wrap search from ptr=3 over {0,1} picks 0.
    add_vec("wrap_r",  5'b00011, 5'b00011, 5'b00000, 1, 5'b00000, 0, 0, 0);
    add_vec("wrap_g0", 5'b00011, 5'b00011, 5'b00001, 1, 5'b00001, 0, 1, 1);
    // Owner 1 mid-packet while a port-0 head waits.
    add_vec("mid_r",   5'b00011, 5'b00011, 5'b00000, 1, 5'b00000, 0, 0, 0);
    add_vec("mid_hd",  5'b00011, 5'b00011, 5'b00000, 1, 5'b00010, 1, 1, 1);
    add_vec("mid_bd",  5'b00011, 5'b00001, 5'b00000, 1, 5'b00010, 1, 1, 1);
    add_vec("mid_bub", 5'b00001, 5'b00011, 5'b00000, 1, 5'b00010, 1, 1, 0);
    add_vec("mid_tl",  5'b00011, 5'b00011, 5'b00010, 1, 5'b00010, 1, 1, 1);
    add_vec("mid_gap", 5'b00001, 5'b00001, 5'b00001, 1, 5'b00000, 0, 0, 0);
    add_vec("mid_g0",  5'b00001, 5'b00001, 5'b00001, 1, 5'b00001, 0, 1, 1);
    add_vec("idle_b",  5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 0, 0, 0);

    // Reset and its state.
    rst_ = 1'b1; req = '0; hd = '0; tl = '0; ordy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.grt", 32'(grt), 32'h0);
    check("rst.owner", 32'(owner), 32'h0);
    check("rst.locked", 32'(locked), 32'h0);
    check("rst.xfer", 32'(xfer), 32'h0);
    check("rst.timeout", 32'(timeout), 32'h0);
    rst_ = 1'b0;

    foreach (vecs[i])
      cyc(vecs[i].name, vecs[i].req, vecs[i].hd, vecs[i].tl, vecs[i].ordy,
          vecs[i].e_grt, vecs[i].e_owner, vecs[i].e_locked, vecs[i].e_xfer, 1'b0);

    // Output stall with owner 3 (ptr=1 here): no xfer, grant held.
    cyc("stall_r", 5'b01000, 5'b01000, 5'b00000, 0, 5'b00000, 0, 0, 0, 0);
    for (int k = 0; k < ORDY_STALL; k++)
      cyc("stall_hold", 5'b01000, 5'b01000, 5'b01000, 0, 5'b01000, 3, 1, 0, 0);
    cyc("stall_go", 5'b01000, 5'b01000, 5'b01000, 1, 5'b01000, 3, 1, 1, 0);
    cyc("stall_rel", 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 0, 0, 0, 0);

    // Reset mid-packet (ptr=4 before it): owner 1 dropped, ptr back to 0.
    cyc("mrst_r", 5'b00010, 5'b00010, 5'b00000, 1, 5'b00000, 0, 0, 0, 0);
    cyc("mrst_hd", 5'b00010, 5'b00010, 5'b00000, 1, 5'b00010, 1, 1, 1, 0);
    rst_ = 1'b1;
    cyc("mrst_bd", 5'b00010, 5'b00000, 5'b00000, 1, 5'b00010, 1, 1, 1, 0);
    rst_ = 1'b0;
    cyc("mrst_post", 5'b10100, 5'b10100, 5'b10100, 1, 5'b00000, 0, 0, 0, 0);
    cyc("mrst_g2", 5'b10100, 5'b10100, 5'b10100, 1, 5'b00100, 2, 1, 1, 0);
    cyc("mrst_r4", 5'b10000, 5'b10000, 5'b10000, 1, 5'b00000, 0, 0, 0, 0);
    cyc("mrst_g4", 5'b10000, 5'b10000, 5'b10000, 1, 5'b10000, 4, 1, 1, 0);
    cyc("mrst_idle", 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 0, 0, 0, 0);

    // Owner 0 goes silent (ptr=0 here).
    cyc("wd_r", 5'b00001, 5'b00001, 5'b00000, 1, 5'b00000, 0, 0, 0, 0);
`ifdef OUTARB_WATCHDOG_EN
    for (int k = 0; k < 5; k++)
      cyc("wd_stall", 5'b00000, 5'b00000, 5'b00000, 1, 5'b00001, 0, 1, 0, 0);
    cyc("wd_fire", 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 0, 0, 0, 1);
    cyc("wd_ptr_r", 5'b00011, 5'b00011, 5'b00000, 1, 5'b00000, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++)
      cyc("wd2_stall", 5'b00000, 5'b00000, 5'b00000, 1, 5'b00010, 1, 1, 0, 0);
    cyc("wd2_tail", 5'b00010, 5'b00000, 5'b00010, 1, 5'b00010, 1, 1, 1, 0);
    cyc("wd2_rel", 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 0, 0, 0, 0);
`else
    for (int k = 0; k < 8; k++)
      cyc("hold", 5'b00000, 5'b00000, 5'b00000, 1, 5'b00001, 0, 1, 0, 0);
    cyc("hold_tail", 5'b00001, 5'b00000, 5'b00001, 1, 5'b00001, 0, 1, 1, 0);
    cyc("hold_rel", 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 0, 0, 0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/outport_arb.md
Name: outport_arb

Overview:
- Per-output-port wormhole switch arbiter. One instance per router output port, five per router.
- Chooses which of NPORT input channels may drive the crossbar to this output. It holds that choice from the head flit to the tail flit, then re-arbitrates round-robin.
- Drives the per-input grant bits that the crossbar and input channels consume.

Parameters:
- NPORT, 5, number of input ports competing for this output.
- PTRW, 3, width of port index; must be at least clog2(NPORT).
- TIMEOUT, 255, stall cycles before forced release (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst_  in  1  synchronous reset, active-high.
- req  in  NPORT  req[i]=1: input i presents a valid flit routed to this output.
- hd  in  NPORT  hd[i]=1: input i's current flit is a head flit.
- tl  in  NPORT  tl[i]=1: input i's current flit is a tail flit. A single-flit packet has hd=tl=1.
- ordy  in  1  output channel can accept a flit this cycle.
- grt  out  NPORT  one-hot grant, registered; all-zero when unlocked.
- owner  out  PTRW  index of granted input; valid only while locked=1.
- locked  out  1  output port is reserved by a packet.
- xfer  out  1  combinational: a flit crosses this cycle.
- timeout  out  1  one-cycle pulse on forced release; tied to 0 when the feature is off.

Behaviour:
- Reset (rst_=1 at posedge):
  - State goes to IDLE.
  - grt=0, owner=0, locked=0, rr pointer ptr=0, stall counter=0, timeout=0.
  - Reset overrides any in-flight packet: the lock is dropped at once, with no tail required.
- States: IDLE and LOCKED.
- IDLE:
  - Candidates are cand = req & hd. Non-head requests are ignored.
  - If cand != 0, pick the first set bit searching from ptr upward, wrapping NPORT-1 -> 0.
  - Next cycle: grt = onehot(pick), owner = pick, locked = 1, state LOCKED.
  - Request-to-grant latency is 1 cycle. xfer = 0 in IDLE.
- LOCKED:
  - xfer = grt[owner] & req[owner] & ordy.
  - Grant is held even if req[owner] deasserts (bubble); other requests are ignored.
  - If xfer & tl[owner]: next cycle state IDLE, grt=0, locked=0, ptr = owner+1, wrapping NPORT-1 -> 0.
  - The single-flit packet case is the same: release follows its one xfer.
- Bubble: there is always at least one IDLE cycle between packets. Back-to-back packets on one output see 1 dead cycle.
- Fairness: the winner becomes lowest priority after release. With all NPORT inputs requesting continuously, each input is granted once per NPORT packets.
- ordy=0 in LOCKED: no xfer and no state change.
- hd asserted by owner mid-packet: ignored, no re-arbitration.
- ptr changes only on release; it never changes in IDLE without a grant.

Optional Feature:
- Macro: OUTARB_WATCHDOG_EN.
- With the macro:
  - An 8-bit-or-wider stall counter runs in LOCKED. It clears on every xfer and on entry to LOCKED, and increments on cycles without xfer.
  - When the counter reaches TIMEOUT, the block releases next cycle exactly as for a tail: IDLE, grt=0, ptr=owner+1.
  - timeout pulses high for that one cycle.
  - If a tail xfer and the TIMEOUT hit coincide, the tail release wins and timeout stays 0.
- Without the macro: no counter, timeout is constant 0, and the lock is held indefinitely until the tail.

Decomposition:
- Shared definitions header/package: NPORT, PTRW, port index constants (0 = local, 1-4 = directions), state encoding (IDLE=0, LOCKED=1), TIMEOUT default.
- Sub-module rr_pick: combinational round-robin priority picker. Inputs cand[NPORT] and ptr[PTRW]; outputs pick[PTRW] and any. Instantiated once here; reusable by the VC allocator.

Test Plan:
- Reset then req=5'b00100, hd=5'b00100:
  - Cycle+1: grt=5'b00100, owner=2, locked=1.
  - 3-flit packet with ordy=1 gives 3 xfer pulses; tail on the third.
  - Then IDLE, grt=0, ptr=3.
- req=hd=5'b11111 held continuously, single-flit packets, ordy=1: grants cycle in order 0,1,2,3,4,0 with one IDLE cycle between each.
- Owner 1 mid-packet while req=5'b00001 with hd=1 arrives: grt stays 5'b00010 until tail xfer of port 1. Port 0 is granted 2 cycles after that tail.
- LOCKED, owner 3, ordy=0 for 10 cycles then 1: xfer=0 for 10 cycles, locked held, grt unchanged; xfer resumes on cycle 11.
- rst_=1 asserted in the middle of a packet: next cycle grt=0, locked=0, ptr=0. A new head on port 4 is then granted normally.
- With OUTARB_WATCHDOG_EN and TIMEOUT=4:
  - Owner 0, req[0]=0 for 4 cycles: timeout pulses 1 cycle, grt=0, ptr=1.
  - Same setup with tail xfer exactly at the count: timeout=0.
